// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - memory map constants, region encoding and sequencer state type
package mem_map_pkg;

    localparam logic [1:0]  RAM_TAG  = 2'b11;
    localparam logic [12:0] ROM_BASE = 13'h0000;
    localparam logic [12:0] RAM_BASE = 13'h1800;

    typedef enum logic {
        REGION_ROM = 1'b0,
        REGION_RAM = 1'b1
    } region_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

endpackage

// File: rtl/mem_region_decode.sv
// rtl/mem_region_decode.sv - address tag to region and one-hot macro select decoder
module mem_region_decode
    import mem_map_pkg::*;
(
    input  logic [1:0] addr_tag,
    output logic       region,
    output logic       rom_hit,
    output logic       ram_hit
);

    // Only the top tag picks RAM; everything else falls into ROM, so there is no hole.
    assign ram_hit = (addr_tag == RAM_TAG);
    assign rom_hit = ~ram_hit;
    assign region  = ram_hit ? REGION_RAM : REGION_ROM;

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - single-outstanding load/store sequencer for ROM/RAM macros
module mem_access_sequencer
    import mem_map_pkg::*;
#(
    parameter int          ADDR_W   = 13,
    parameter int          DATA_W   = 32,
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rom_sel,
    output logic              ram_sel,
    output logic              ram_we,
    input  logic [DATA_W-1:0] rom_rdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    generate
        if (ROM_WAIT > 15 || RAM_WAIT > 15) begin : g_bad_wait
            $error("mem_access_sequencer: ROM_WAIT and RAM_WAIT must be in 0..15");
        end
    endgenerate

    localparam logic [3:0] ROM_WAIT_C = ROM_WAIT[3:0];
    localparam logic [3:0] RAM_WAIT_C = RAM_WAIT[3:0];

    state_t     state;
    logic [3:0] cnt;
    logic       region_q;
    logic       we_q;
    logic       dec_region;
    logic       dec_rom;
    logic       dec_ram;

    mem_region_decode u_decode (
        .addr_tag (req_addr[ADDR_W-1:ADDR_W-2]),
        .region   (dec_region),
        .rom_hit  (dec_rom),
        .ram_hit  (dec_ram)
    );

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rom_sel   = (state == ST_ACCESS) && (region_q == REGION_ROM);
    assign ram_sel   = (state == ST_ACCESS) && (region_q == REGION_RAM);
    // Write strobe lands on the last access cycle so the macro sees a settled address.
    assign ram_we    = ram_sel && we_q && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            region_q  <= REGION_ROM;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        we_q      <= req_we;
                        region_q  <= dec_region;
                        cnt       <= dec_ram ? RAM_WAIT_C : ROM_WAIT_C;
                        // A ROM store never touches the macro; answer with an error straight away.
                        if (dec_rom && req_we) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= ST_RESP;
                        end else begin
                            state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (we_q) begin
                            rsp_rdata <= '0;
                        end else if (region_q == REGION_RAM) begin
                            rsp_rdata <= ram_rdata;
                        end else begin
                            rsp_rdata <= rom_rdata;
                        end
                        rsp_err <= 1'b0;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
